hack_memory_map_ctrl: RTL and testbench
=======================================

// Module: hack_memory_map_ctrl
// PURPOSE
//  Parametrised, clocked successor to the combinational Hack data-memory map: RAM, screen buffer and keyboard behind one address bus.
//  Registered read data with 1-cycle latency; buffered keyboard FIFO; second screen read port for the display scanner.
//  Sticky error flags for unmapped accesses and keyboard overflow. Sits between the CPU data port and RAM/screen/keyboard.
// PARAMETERS
//  DATA_W       16      data word width
//  ADDR_W       15      CPU address width
//  RAM_WORDS    16384   RAM size; occupies 0 .. RAM_WORDS-1
//  SCREEN_BASE  'h4000  first screen address
//  SCREEN_WORDS 8192    screen size (power of 2)
//  KBD_ADDR     'h6000  keyboard register address
//  KBD_DEPTH    4       keyboard FIFO depth (power of 2, >=2)
// PORTS
//  clk        in   1                        system clock, rising edge
//  reset      in   1                        asynchronous, active-high reset
//  in         in   DATA_W                   CPU write data
//  load       in   1                        CPU write enable, sampled at clk rise
//  address    in   ADDR_W                   CPU address
//  out        out  DATA_W                   registered CPU read data
//  kbd_code   in   DATA_W                   scancode from keyboard interface
//  kbd_push   in   1                        enqueue kbd_code this cycle
//  kbd_count  out  $clog2(KBD_DEPTH)+1      FIFO occupancy
//  kbd_full   out  1                        kbd_count == KBD_DEPTH
//  scr_raddr  in   $clog2(SCREEN_WORDS)     display-side screen word index
//  scr_rdata  out  DATA_W                   registered screen data for scr_raddr
//  addr_err   out  1                        sticky: unmapped address accessed
//  kbd_ovf    out  1                        sticky: push while full
// BEHAVIOUR
//  Reset: out, scr_rdata, kbd_count, addr_err, kbd_ovf = 0; FIFO pointers = 0. RAM/screen contents not cleared.
//  Reset asserted mid-operation: FIFO empties immediately, any in-flight write is discarded.
//  Decode: RAM if address < RAM_WORDS; screen if SCREEN_BASE <= address < SCREEN_BASE+SCREEN_WORDS.
//   Keyboard if address == KBD_ADDR; every other address is unmapped.
//  Write (load=1): RAM/screen word updated at the clk edge. Writes to KBD_ADDR pop the FIFO (data ignored); no-op if empty.
//  Read: out at edge N+1 reflects address at edge N. Write-first: load with same address gives out = in on the next cycle.
//  Keyboard read: out = FIFO head, or 0 if empty; reading does not pop.
//  Unmapped access (read or write): out = 0, write discarded, addr_err set until reset.
//  FIFO: push when not full enqueues kbd_code. Push when full drops the code and sets kbd_ovf.
//   Push and pop in the same cycle: when full, both happen and count is unchanged; when empty, push only and count becomes 1.
//   Pointers wrap modulo KBD_DEPTH.
//  Screen port: scr_rdata at edge N+1 = screen[scr_raddr at edge N].
//   Same-cycle CPU screen write to that index gives the new data (write-first).
//  No combinational path from any input to any output.
// TESTING
//  1 Write 'hA0+i to RAM 0..15, then read back -> out == 'hA0+i one cycle after address applied; read of 'h3FFF returns last value written there.
//  2 Write 'hB0+i to 'h4000+i; drive scr_raddr=i -> scr_rdata == 'hB0+i next cycle; same-cycle CPU write to 'h4005 with scr_raddr=5 -> new value.
//  3 Push 'h41,'h42 -> kbd_count=2, read KBD_ADDR -> 'h41; write KBD_ADDR -> next read 'h42; pop again -> read 0, count 0.
//  4 Push 5 codes with KBD_DEPTH=4 -> kbd_full=1, kbd_ovf=1, FIFO holds first 4; push+pop same cycle while full -> count stays 4, order kept.
//  5 Read 'h7000 -> out=0, addr_err=1; write 'h6001 -> no RAM/screen change, addr_err stays 1 until reset.
//  6 Assert reset between edges with FIFO non-empty -> out, kbd_count, flags 0 immediately; RAM words written earlier still read back.

Source files
------------

// File: rtl/hack_memory_map_ctrl.sv
// -----------------------------------------------------------------------------
// hack_memory_map_ctrl
//   Clocked Hack data-memory map. RAM, screen buffer and a keyboard FIFO share
//   one CPU address bus. Read data is registered, so it has one cycle of
//   latency. A second, read-only screen port serves the display scanner.
//   Sticky flags record unmapped accesses and keyboard FIFO overflow.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   in         in   DATA_W CPU write data
//   load       in   1      CPU write enable
//   address    in   ADDR_W CPU address
//   out        out  DATA_W registered CPU read data
//   kbd_code   in   DATA_W scancode from the keyboard interface
//   kbd_push   in   1      enqueue kbd_code this cycle
//   kbd_count  out  log2(KBD_DEPTH)+1  FIFO occupancy
//   kbd_full   out  1      FIFO holds KBD_DEPTH codes
//   scr_raddr  in   log2(SCREEN_WORDS) display-side screen word index
//   scr_rdata  out  DATA_W registered screen data for scr_raddr
//   addr_err   out  1      sticky: an unmapped address was accessed
//   kbd_ovf    out  1      sticky: a scancode was dropped because FIFO was full
// -----------------------------------------------------------------------------
module hack_memory_map_ctrl #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_BASE  = 'h4000,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_ADDR     = 'h6000,
  parameter int KBD_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               in,
  input  logic                            load,
  input  logic [ADDR_W-1:0]               address,
  output logic [DATA_W-1:0]               out,
  input  logic [DATA_W-1:0]               kbd_code,
  input  logic                            kbd_push,
  output logic [$clog2(KBD_DEPTH):0]      kbd_count,
  output logic                            kbd_full,
  input  logic [$clog2(SCREEN_WORDS)-1:0] scr_raddr,
  output logic [DATA_W-1:0]               scr_rdata,
  output logic                            addr_err,
  output logic                            kbd_ovf
);

  // One extra address bit so that region limits equal to 2**ADDR_W still fit.
  localparam int AW1    = ADDR_W + 1;
  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  localparam int PTR_W  = $clog2(KBD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [AW1-1:0]   L_RAM_END   = AW1'(RAM_WORDS);
  localparam logic [AW1-1:0]   L_SCR_BASE  = AW1'(SCREEN_BASE);
  localparam logic [AW1-1:0]   L_SCR_END   = AW1'(SCREEN_BASE + SCREEN_WORDS);
  localparam logic [AW1-1:0]   L_KBD_ADDR  = AW1'(KBD_ADDR);
  localparam logic [CNT_W-1:0] L_KBD_DEPTH = CNT_W'(KBD_DEPTH);

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_SCR  = 2'd1,
    SEL_KBD  = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  // Address decode; the first matching region wins.
  function automatic sel_e decode_region(input logic [AW1-1:0] a);
    sel_e s;
    if (a < L_RAM_END) begin
      s = SEL_RAM;
    end else if ((a >= L_SCR_BASE) && (a < L_SCR_END)) begin
      s = SEL_SCR;
    end else if (a == L_KBD_ADDR) begin
      s = SEL_KBD;
    end else begin
      s = SEL_NONE;
    end
    return s;
  endfunction

  // Storage
  logic [DATA_W-1:0] r_ram  [RAM_WORDS];
  logic [DATA_W-1:0] r_scr  [SCREEN_WORDS];
  logic [DATA_W-1:0] r_fifo [KBD_DEPTH];

  // Control / output registers
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_scr_rdata;
  logic              r_addr_err;
  logic              r_kbd_ovf;

  // Combinational nets
  logic [AW1-1:0]    w_addr_ext;
  logic [AW1-1:0]    w_scr_off;
  sel_e              w_sel;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [SCR_AW-1:0] w_scr_idx;
  logic              w_ram_we;
  logic              w_scr_we;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_do_pop;
  logic              w_do_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_fifo_head;
  logic [DATA_W-1:0] w_rd_next;
  logic [DATA_W-1:0] w_scr_next;
  logic              w_unused_scr_off;

  assign w_addr_ext = {1'b0, address};
  assign w_scr_off  = w_addr_ext - L_SCR_BASE;
  assign w_ram_idx  = w_addr_ext[RAM_AW-1:0];
  assign w_scr_idx  = w_scr_off[SCR_AW-1:0];
  // Upper offset bits are fixed by the decode, only the index bits matter.
  assign w_unused_scr_off = ^w_scr_off;

  // Region select and CPU write enables.
  always_comb begin
    w_sel    = decode_region(w_addr_ext);
    w_ram_we = load && (w_sel == SEL_RAM);
    w_scr_we = load && (w_sel == SEL_SCR);
  end

  // Keyboard FIFO push/pop arbitration and next occupancy.
  // A pop frees the slot first, so a push is accepted when full only if a pop
  // happens in the same cycle; a pop of an empty FIFO does nothing.
  always_comb begin
    w_fifo_empty = (r_count == CNT_W'(0));
    w_fifo_full  = (r_count == L_KBD_DEPTH);
    w_fifo_head  = r_fifo[r_rd_ptr];
    w_do_pop     = load && (w_sel == SEL_KBD) && !w_fifo_empty;
    w_do_push    = kbd_push && (!w_fifo_full || w_do_pop);
    w_drop       = kbd_push && w_fifo_full && !w_do_pop;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // CPU read data; a write to RAM/screen returns the written word (write-first).
  always_comb begin
    case (w_sel)
      SEL_RAM: begin
        if (load) begin
          w_rd_next = in;
        end else begin
          w_rd_next = r_ram[w_ram_idx];
        end
      end
      SEL_SCR: begin
        if (load) begin
          w_rd_next = in;
        end else begin
          w_rd_next = r_scr[w_scr_idx];
        end
      end
      SEL_KBD: begin
        if (w_fifo_empty) begin
          w_rd_next = {DATA_W{1'b0}};
        end else begin
          w_rd_next = w_fifo_head;
        end
      end
      default: w_rd_next = {DATA_W{1'b0}};
    endcase
  end

  // Display port read; a same-cycle CPU write to the same word forwards.
  always_comb begin
    if (w_scr_we && (w_scr_idx == scr_raddr)) begin
      w_scr_next = in;
    end else begin
      w_scr_next = r_scr[scr_raddr];
    end
  end

  // Array writes; contents survive reset but no write lands while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset) begin
      if (w_ram_we) begin
        r_ram[w_ram_idx] <= in;
      end
      if (w_scr_we) begin
        r_scr[w_scr_idx] <= in;
      end
      if (w_do_push) begin
        r_fifo[r_wr_ptr] <= kbd_code;
      end
    end
  end

  // Output registers, FIFO pointers/occupancy and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= {DATA_W{1'b0}};
      r_scr_rdata <= {DATA_W{1'b0}};
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_full      <= 1'b0;
      r_addr_err  <= 1'b0;
      r_kbd_ovf   <= 1'b0;
    end else begin
      r_out       <= w_rd_next;
      r_scr_rdata <= w_scr_next;
      r_count     <= w_count_next;
      r_full      <= (w_count_next == L_KBD_DEPTH);
      r_addr_err  <= r_addr_err | (w_sel == SEL_NONE);
      r_kbd_ovf   <= r_kbd_ovf | w_drop;
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
    end
  end

  assign out       = r_out;
  assign scr_rdata = r_scr_rdata;
  assign kbd_count = r_count;
  assign kbd_full  = r_full;
  assign addr_err  = r_addr_err;
  assign kbd_ovf   = r_kbd_ovf;

endmodule

// File: tb/tb_hack_memory_map_ctrl.sv
// Scoreboard bench for hack_memory_map_ctrl: the stimulus process queues the
// expected post-edge state from a behavioural memory-map model; the monitor
// pops and compares on the falling edge after the clock edge it refers to.
module tb_hack_memory_map_ctrl;

  localparam int SCR_BASE = 'h4000;
  localparam int SCR_WDS  = 8192;
  localparam int RAM_WDS  = 16384;
  localparam int KBD_A    = 'h6000;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] tb_in = 16'h0000;
  logic        load = 1'b0;
  logic [14:0] address = 15'h0000;
  logic [15:0] tb_out;
  logic [15:0] kbd_code = 16'h0000;
  logic        kbd_push = 1'b0;
  logic [2:0]  kbd_count;
  logic        kbd_full;
  logic [12:0] scr_raddr = 13'h0000;
  logic [15:0] scr_rdata;
  logic        addr_err;
  logic        kbd_ovf;

  hack_memory_map_ctrl dut (
    .clk(clk), .reset(reset), .in(tb_in), .load(load), .address(address),
    .out(tb_out), .kbd_code(kbd_code), .kbd_push(kbd_push),
    .kbd_count(kbd_count), .kbd_full(kbd_full), .scr_raddr(scr_raddr),
    .scr_rdata(scr_rdata), .addr_err(addr_err), .kbd_ovf(kbd_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] out;
    bit          out_k;
    logic [15:0] scr;
    bit          scr_k;
    int          cnt;
    bit          full;
    bit          err;
    bit          ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;

  // Reference model state
  logic [15:0] m_ram [int];
  logic [15:0] m_scr [int];
  logic [15:0] m_fifo[$];
  bit          m_err = 1'b0;
  bit          m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every queued expectation whose clock edge has passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      if (me.out_k) chk("out", {16'h0, tb_out}, {16'h0, me.out});
      if (me.scr_k) chk("scr_rdata", {16'h0, scr_rdata}, {16'h0, me.scr});
      chk("kbd_count", {29'h0, kbd_count}, me.cnt);
      chk("kbd_full", {31'h0, kbd_full}, {31'h0, me.full});
      chk("addr_err", {31'h0, addr_err}, {31'h0, me.err});
      chk("kbd_ovf", {31'h0, kbd_ovf}, {31'h0, me.ovf});
    end
  end

  // One clock of stimulus; called just after a falling edge.
  task automatic step(input logic ld, input int a, input logic [15:0] d,
                      input logic ps, input logic [15:0] kc, input int sa);
    exp_t e;
    bit is_ram, is_scr, is_kbd, was_full, popped;
    load = ld; address = 15'(a); tb_in = d; kbd_push = ps; kbd_code = kc;
    scr_raddr = 13'(sa);
    is_ram = (a < RAM_WDS);
    is_scr = (a >= SCR_BASE) && (a < SCR_BASE + SCR_WDS);
    is_kbd = (a == KBD_A);
    e.out_k = 1'b1;
    e.scr_k = 1'b1;
    if (is_ram) begin
      if (ld) e.out = d;
      else if (m_ram.exists(a)) e.out = m_ram[a];
      else begin e.out = 16'h0; e.out_k = 1'b0; end
    end else if (is_scr) begin
      if (ld) e.out = d;
      else if (m_scr.exists(a - SCR_BASE)) e.out = m_scr[a - SCR_BASE];
      else begin e.out = 16'h0; e.out_k = 1'b0; end
    end else if (is_kbd) begin
      e.out = (m_fifo.size() > 0) ? m_fifo[0] : 16'h0;
    end else begin
      e.out = 16'h0;
      m_err = 1'b1;
    end
    if (ld && is_scr && (a - SCR_BASE) == sa) e.scr = d;
    else if (m_scr.exists(sa)) e.scr = m_scr[sa];
    else begin e.scr = 16'h0; e.scr_k = 1'b0; end
    if (ld && is_ram) m_ram[a] = d;
    if (ld && is_scr) m_scr[a - SCR_BASE] = d;
    was_full = (m_fifo.size() == DEPTH);
    popped = 1'b0;
    if (ld && is_kbd && m_fifo.size() > 0) begin
      void'(m_fifo.pop_front());
      popped = 1'b1;
    end
    if (ps) begin
      if (!was_full || popped) m_fifo.push_back(kc);
      else m_ovf = 1'b1;
    end
    e.cnt  = m_fifo.size();
    e.full = (m_fifo.size() == DEPTH);
    e.err  = m_err;
    e.ovf  = m_ovf;
    e.cyc  = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out"}, {16'h0, tb_out}, 32'h0);
    chk({tag, "_scr_rdata"}, {16'h0, scr_rdata}, 32'h0);
    chk({tag, "_kbd_count"}, {29'h0, kbd_count}, 32'h0);
    chk({tag, "_kbd_full"}, {31'h0, kbd_full}, 32'h0);
    chk({tag, "_addr_err"}, {31'h0, addr_err}, 32'h0);
    chk({tag, "_kbd_ovf"}, {31'h0, kbd_ovf}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;

    // 1: RAM write/read-back and top RAM word
    for (int i = 0; i < 16; i++) step(1'b1, i, 16'(16'hA0 + i), 1'b0, 16'h0, 0);
    for (int i = 0; i < 16; i++) step(1'b0, i, 16'h0, 1'b0, 16'h0, 0);
    step(1'b1, 'h3FFF, 16'h1111, 1'b0, 16'h0, 0);
    step(1'b1, 'h3FFF, 16'h2222, 1'b0, 16'h0, 0);
    step(1'b0, 'h3FFF, 16'h0, 1'b0, 16'h0, 0);

    // 2: screen writes, display port reads and forwarding
    for (int i = 0; i < 8; i++) step(1'b1, SCR_BASE + i, 16'(16'hB0 + i), 1'b0, 16'h0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, SCR_BASE + i, 16'h0, 1'b0, 16'h0, i);
    step(1'b1, SCR_BASE + 5, 16'h1234, 1'b0, 16'h0, 5);
    step(1'b0, 0, 16'h0, 1'b0, 16'h0, 5);

    // 3: keyboard FIFO basic order, pop, empty read
    step(1'b0, 0, 16'h0, 1'b1, 16'h41, 0);
    step(1'b0, 0, 16'h0, 1'b1, 16'h42, 0);
    step(1'b0, KBD_A, 16'h0, 1'b0, 16'h0, 0);
    step(1'b1, KBD_A, 16'hFFFF, 1'b0, 16'h0, 0);
    step(1'b0, KBD_A, 16'h0, 1'b0, 16'h0, 0);
    step(1'b1, KBD_A, 16'h0, 1'b0, 16'h0, 0);
    step(1'b0, KBD_A, 16'h0, 1'b0, 16'h0, 0);
    step(1'b1, KBD_A, 16'h0, 1'b1, 16'h43, 0);   // pop on empty + push
    step(1'b1, KBD_A, 16'h0, 1'b0, 16'h0, 0);

    // 4: overflow, then push+pop while full
    for (int i = 0; i < 5; i++) step(1'b0, 0, 16'h0, 1'b1, 16'(16'h50 + i), 0);
    step(1'b1, KBD_A, 16'h0, 1'b1, 16'h60, 0);
    for (int i = 0; i < 5; i++) step(1'b1, KBD_A, 16'h0, 1'b0, 16'h0, 0);

    // 5: unmapped read and write
    step(1'b0, 'h7000, 16'h0, 1'b0, 16'h0, 0);
    step(1'b1, 'h6001, 16'hEEEE, 1'b0, 16'h0, 1);
    for (int i = 0; i < 4; i++) step(1'b0, i, 16'h0, 1'b0, 16'h0, i);

    // 6: reset mid-cycle with FIFO non-empty and a write in flight
    step(1'b0, 0, 16'h0, 1'b1, 16'h71, 0);
    step(1'b0, 0, 16'h0, 1'b1, 16'h72, 0);
    load = 1'b1; address = 15'd3; tb_in = 16'hDEAD;
    #1 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    #1 reset = 1'b0;
    m_fifo.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b0, i, 16'h0, 1'b0, 16'h0, i);
    step(1'b0, KBD_A, 16'h0, 1'b0, 16'h0, 0);

    // Randomised traffic over a few RAM/screen windows, keyboard and holes
    for (int n = 0; n < 400; n++) begin
      int a, k, sa;
      k = $urandom_range(0, 19);
      if (k < 8)       a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range('h3FF0, 'h3FFF);
      else if (k < 15) a = ($urandom_range(0, 1) == 0) ? SCR_BASE + $urandom_range(0, 31) : $urandom_range('h5FF0, 'h5FFF);
      else if (k < 19) a = KBD_A;
      else             a = $urandom_range('h6001, 'h7FFF);
      sa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range('h1FF0, 'h1FFF);
      step(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, a, 16'($urandom),
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 16'($urandom), sa);
    end

    load = 1'b0;
    kbd_push = 1'b0;
    address = 15'd0;
    repeat (3) @(negedge clk);
    #1 chk("queue_drained", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
